disaggregator: RTL and testbench
================================

Name: disaggregator

Overview:
- Downstream counterpart of the aggregator: dequeues packed words of FETCH_WIDTH lanes × DATA_WIDTH bits and replays them one lane per cycle into a narrow FIFO-style receiver.
- Number of valid lanes per packed word is runtime-programmable, mirroring the aggregator's fetch-width control.
- Sits between the wide aggregated-word FIFO and narrow per-element consumers (e.g. patch/ANN compare datapath).

Parameters:
- DATA_WIDTH, 8, bits per lane.
- FETCH_WIDTH, 6, physical lanes per packed word.
- CNT_WIDTH, 3, width of lane index and fetch-width fields; must hold FETCH_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sender_data  in  FETCH_WIDTH*DATA_WIDTH  packed word; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- sender_empty_n  in  1  upstream has a packed word.
- sender_deq  out  1  combinational dequeue strobe.
- receiver_data  out  DATA_WIDTH  current lane.
- receiver_full_n  in  1  downstream can accept.
- receiver_enq  out  1  combinational enqueue strobe.
- change_fetch_width  in  1  latch input_fetch_width this edge.
- input_fetch_width  in  CNT_WIDTH  requested valid lanes per word.
- busy  out  1  high while a packed word is being replayed.

Behaviour:
- Reset (async assert, sync release on clk): state=IDLE, lane index=0, shift register=0, width_q=FETCH_WIDTH; sender_deq=0, receiver_enq=0, receiver_data=0, busy=0.
- Width register: on a rising edge with change_fetch_width=1, width_q <= input_fetch_width, saturated to FETCH_WIDTH; value 0 is ignored (width_q holds). A change lands at any time. The load on that same edge uses the old width_q; new width applies from the next load onward. A word already in replay always finishes with the width it was loaded with (captured into len_q at load).
- States:
  - IDLE:
    - sender_deq = sender_empty_n.
    - On deq: data_q <= sender_data, len_q <= width_q, idx <= 0, go to SHIFT.
  - SHIFT:
    - busy=1; receiver_data = lane idx of data_q.
    - receiver_enq = receiver_full_n.
    - On enq with idx < len_q-1: idx++.
    - On enq with idx == len_q-1:
      - If sender_empty_n: sender_deq=1 the same cycle, reload data_q/len_q, idx <= 0, stay in SHIFT. Zero bubble: sustained 1 lane/cycle.
      - Else: go to IDLE.
- Latency: packed word dequeued at edge N; lane 0 presented (receiver_enq possible) in cycle N+1.
- receiver_full_n=0 in SHIFT: hold idx, data_q, and receiver_data stable; no enq.
- sender_deq is never asserted in SHIFT except on the final-lane enq cycle. It is never asserted when sender_empty_n=0.
- Lanes at index ≥ len_q are discarded, never emitted.
- receiver_data in IDLE holds the last emitted lane. Not meaningful without enq.
- Reset mid-replay: partially replayed word is lost; width_q returns to FETCH_WIDTH.

Optional Feature:
- Macro DISAGG_LAST_EN.
  - Defined: adds output port receiver_last (1 bit), high with receiver_enq on lane len_q-1 of each word, 0 otherwise and at reset.
  - Undefined: port absent, no extra logic.

Test Plan:
- Default width 6, upstream words 0x050403020100, 0x0B0A09080706 back-to-back, receiver always ready -> receiver_data 0x00..0x0B on 12 consecutive cycles, no bubble at the word boundary; sender_deq high exactly twice.
- change_fetch_width=1, input_fetch_width=4 while IDLE, word 0x050403020100 -> emits 00,01,02,03 only, then IDLE; busy falls.
- Width change to 2 issued at lane 1 of a width-6 word -> current word emits all 6 lanes; next word emits 2 lanes.
- input_fetch_width=0 and =7 -> width_q unchanged (6) and saturated to 6 respectively.
- receiver_full_n toggled randomly over 50 words of incrementing data -> output stream strictly incrementing, no loss/duplication; receiver_data stable while full_n=0.
- rst_n pulsed low at lane 3 -> all outputs 0 immediately, width_q=6; next word replays from lane 0.

Source files
------------

// File: rtl/disaggregator_if.sv
// Sender/receiver handshake bundle for the disaggregator (wide packed words in, single lanes out).
// DISAGG_LAST_EN adds receiver_last to the receiver side.
interface disaggregator_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 6
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
`ifdef DISAGG_LAST_EN
  logic                              receiver_last;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq, receiver_last
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq, receiver_last
  );
`else
  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );
`endif
endinterface

// File: rtl/disaggregator.sv
// Replays packed FETCH_WIDTH-lane words one lane per cycle into a narrow FIFO-style receiver.
// Optional DISAGG_LAST_EN: drives receiver_last with the final lane of every word.
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 6,
  parameter int unsigned CNT_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  disaggregator_if.slave       bus,
  input  logic                 change_fetch_width,
  input  logic [CNT_WIDTH-1:0] input_fetch_width,
  output logic                 busy
);

  localparam int unsigned WORD_WIDTH = FETCH_WIDTH * DATA_WIDTH;
  localparam int unsigned NUM_SLOTS  = 1 << CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FULL_WIDTH = CNT_WIDTH'(FETCH_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [WORD_WIDTH-1:0]  data_q;
  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   idx_q;
  logic [CNT_WIDTH-1:0]   width_q;
  logic [CNT_WIDTH-1:0]   req_width;
  logic [DATA_WIDTH-1:0]  lanes [NUM_SLOTS];
  logic                   last_lane;
  logic                   load;
  logic                   advance;
  logic                   deq;
  logic                   enq;
  logic                   last_c;

  assign last_lane = (idx_q == (len_q - CNT_WIDTH'(1)));

  // Requested width saturated to the physical lane count.
  always_comb begin
    req_width = input_fetch_width;
    if (32'(input_fetch_width) > FETCH_WIDTH) begin
      req_width = FULL_WIDTH;
    end
  end

  // Lane view of the held word; slots beyond FETCH_WIDTH read as zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      lanes[i] = '0;
    end
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      lanes[i] = data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.sender_empty_n) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.receiver_full_n && last_lane && !bus.sender_empty_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and datapath controls; a final-lane enq reloads in the same cycle for zero bubble.
  always_comb begin
    deq     = 1'b0;
    enq     = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    busy    = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        deq  = bus.sender_empty_n;
        load = bus.sender_empty_n;
      end
      SHIFT: begin
        busy   = 1'b1;
        enq    = bus.receiver_full_n;
        last_c = bus.receiver_full_n && last_lane;
        if (bus.receiver_full_n && last_lane) begin
          deq  = bus.sender_empty_n;
          load = bus.sender_empty_n;
        end else begin
          advance = bus.receiver_full_n;
        end
      end
      default: ;
    endcase
  end

  // Word buffer, captured length and lane index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      len_q  <= FULL_WIDTH;
      idx_q  <= '0;
    end else if (load) begin
      data_q <= bus.sender_data;
      len_q  <= width_q;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q  <= idx_q + CNT_WIDTH'(1);
    end
  end

  // Programmable lane count; zero requests are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= FULL_WIDTH;
    end else if (change_fetch_width && (input_fetch_width != '0)) begin
      width_q <= req_width;
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = lanes[idx_q];

`ifdef DISAGG_LAST_EN
  assign bus.receiver_last = last_c;
`else
  logic unused_last;
  assign unused_last = last_c;
`endif

  a_deq_needs_word: assert property (@(posedge clk) disable iff (!rst_n)
    deq |-> bus.sender_empty_n);

  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (len_q != '0) && (32'(len_q) <= FETCH_WIDTH) && (idx_q < len_q));

endmodule

// File: tb/tb_disaggregator.sv
// Scoreboard bench for disaggregator: randomized upstream/downstream traffic against a lane-queue model.
module tb_disaggregator;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 6;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          change_fetch_width;
  logic [CW-1:0] input_fetch_width;
  logic          busy;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus.slave),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .busy               (busy)
  );

  exp_t              exp_q[$];
  logic [FW*DW-1:0]  up_q[$];
  int                vecs;
  int                miscmp;
  int                model_w;
  int                deq_cnt;
  int                enq_cnt;
  int                cyc;
  int                first_enq;
  int                last_enq;
  bit                full_rand;
  bit                gap_rand;
  bit                hold_empty;
  bit                prev_stall;
  logic [DW-1:0]     prev_data;
  exp_t              e;
  bit                got_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      miscmp++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the expected lane whenever the DUT enqueues.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && busy) chk("stall_hold", 64'(bus.receiver_data), 64'(prev_data));
      got_last = 1'b0;
      if (bus.receiver_enq) begin
        if (exp_q.size() == 0) begin
          vecs++;
          miscmp++;
          $display("FAIL unexpected_enq: actual data=%0h required=no output", bus.receiver_data);
        end else begin
          e = exp_q.pop_front();
          got_last = e.last;
          chk("lane_data", 64'(bus.receiver_data), 64'(e.data));
`ifdef DISAGG_LAST_EN
          chk("lane_last", 64'(bus.receiver_last), 64'(e.last));
`endif
        end
        if (enq_cnt == 0) first_enq = cyc;
        last_enq = cyc;
        enq_cnt++;
      end
`ifdef DISAGG_LAST_EN
      else chk("last_idle", 64'(bus.receiver_last), 64'd0);
`endif
      if (bus.sender_deq && busy) begin
        vecs++;
        if (!(bus.receiver_enq && got_last)) begin
          miscmp++;
          $display("FAIL deq_mid_word: actual deq=1 enq=%0b required deq only on final-lane enq",
                   bus.receiver_enq);
        end
      end
      prev_stall = busy && !bus.receiver_full_n;
      prev_data  = bus.receiver_data;
    end
  end

  // One cycle of stimulus: drive at negedge, observe the dequeue strobe, update the model.
  task automatic tick(input bit chg, input logic [CW-1:0] w);
    logic [FW*DW-1:0] word;
    bit avail;
    change_fetch_width = chg;
    input_fetch_width  = w;
    avail = (up_q.size() != 0) && !hold_empty && (!gap_rand || ($urandom_range(3) != 0));
    bus.sender_empty_n = avail;
    if (avail) bus.sender_data = up_q[0];
    else       bus.sender_data = '0;
    bus.receiver_full_n = full_rand ? ($urandom_range(2) != 0) : 1'b1;
    #2;
    if (rst_n) begin
      if (!avail) begin
        chk("deq_when_empty", 64'(bus.sender_deq), 64'd0);
      end else if (bus.sender_deq) begin
        word = up_q.pop_front();
        deq_cnt++;
        for (int i = 0; i < model_w; i++) begin
          exp_q.push_back(exp_t'{word[i*DW +: DW], (i == model_w - 1)});
        end
      end
      if (chg && (w != 0)) model_w = (int'(w) > FW) ? FW : int'(w);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0 || busy) && n < 4000) begin
      tick(1'b0, '0);
      n++;
    end
    if (n >= 4000) begin
      vecs++;
      miscmp++;
      $display("FAIL %s_drain: actual pending=%0d required 0 within budget", name, exp_q.size());
    end
  endtask

  task automatic clear_counts();
    deq_cnt = 0;
    enq_cnt = 0;
  endtask

  function automatic logic [FW*DW-1:0] inc_word(input int base);
    logic [FW*DW-1:0] w;
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'(base + i);
    return w;
  endfunction

  initial begin
    int n;
    vecs = 0; miscmp = 0; model_w = FW; cyc = 0;
    full_rand = 0; gap_rand = 0; hold_empty = 0; prev_stall = 0;
    clear_counts();
    rst_n = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width  = '0;
    bus.sender_empty_n  = 1'b0;
    bus.sender_data     = '0;
    bus.receiver_full_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_deq",  64'(bus.sender_deq),    64'd0);
    chk("rst_enq",  64'(bus.receiver_enq),  64'd0);
    chk("rst_data", 64'(bus.receiver_data), 64'd0);
    chk("rst_busy", 64'(busy),              64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back default-width words, no bubble at the boundary.
    clear_counts();
    up_q.push_back(48'h050403020100);
    up_q.push_back(48'h0B0A09080706);
    drain("b2b");
    chk("b2b_deq_cnt", 64'(deq_cnt), 64'd2);
    chk("b2b_enq_cnt", 64'(enq_cnt), 64'd12);
    chk("b2b_span",    64'(last_enq - first_enq), 64'd11);

    // Width 4 programmed while idle.
    tick(1'b1, CW'(4));
    clear_counts();
    up_q.push_back(48'h050403020100);
    drain("w4");
    chk("w4_enq_cnt", 64'(enq_cnt), 64'd4);
    chk("w4_busy",    64'(busy),    64'd0);

    // Width change to 2 while lane 1 of a width-6 word is presented.
    tick(1'b1, CW'(6));
    clear_counts();
    up_q.push_back(48'h161514131211);
    up_q.push_back(48'h262524232221);
    n = 0;
    while (enq_cnt < 1 && n < 100) begin tick(1'b0, '0); n++; end
    tick(1'b1, CW'(2));
    drain("mid_change");
    chk("mid_change_enq_cnt", 64'(enq_cnt), 64'd8);

    // Zero is ignored, oversize saturates.
    tick(1'b1, CW'(6));
    tick(1'b1, CW'(0));
    clear_counts();
    up_q.push_back(48'h353433323130);
    drain("w0");
    chk("w0_enq_cnt", 64'(enq_cnt), 64'd6);
    tick(1'b1, CW'(3));
    tick(1'b1, CW'(7));
    clear_counts();
    up_q.push_back(48'h454443424140);
    drain("w7");
    chk("w7_enq_cnt", 64'(enq_cnt), 64'd6);

    // 50 incrementing words with random backpressure and upstream gaps.
    full_rand = 1; gap_rand = 1;
    clear_counts();
    for (int k = 0; k < 50; k++) up_q.push_back(inc_word(k * FW));
    drain("rand");
    chk("rand_deq_cnt", 64'(deq_cnt), 64'd50);
    chk("rand_enq_cnt", 64'(enq_cnt), 64'd300);

    // Random data with random width changes landing at arbitrary times.
    clear_counts();
    for (int k = 0; k < 30; k++) up_q.push_back({$urandom, $urandom});
    n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0 || busy) && n < 4000) begin
      tick($urandom_range(4) == 0, CW'($urandom_range(7)));
      n++;
    end
    chk("rwidth_deq_cnt", 64'(deq_cnt), 64'd30);
    full_rand = 0; gap_rand = 0;

    // Reset while lane 3 of a width-5 word is presented.
    tick(1'b1, CW'(5));
    clear_counts();
    up_q.push_back(48'h555453525150);
    up_q.push_back(48'h656463626160);
    n = 0;
    while (enq_cnt < 3 && n < 100) begin tick(1'b0, '0); n++; end
    hold_empty = 1;
    bus.sender_empty_n = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 64'(bus.receiver_data), 64'd0);
    chk("mid_rst_enq",  64'(bus.receiver_enq),  64'd0);
    chk("mid_rst_deq",  64'(bus.sender_deq),    64'd0);
    chk("mid_rst_busy", 64'(busy),              64'd0);
    exp_q.delete();
    model_w = FW;
    @(negedge clk);
    rst_n = 1'b1;
    hold_empty = 0;
    clear_counts();
    drain("post_rst");
    chk("post_rst_deq_cnt", 64'(deq_cnt), 64'd1);
    chk("post_rst_enq_cnt", 64'(enq_cnt), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
